// File: rtl/sipo_8to128_pkg.sv
// Shared AES data-path definitions for the byte-serial <-> 128-bit block converters.
// State numbering lines up with the serializer's IDLE/TRANS/OVER so both ends
// report the same codes on debug buses.
package sipo_8to128_pkg;

  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned BLOCK_W     = 128;
  localparam int unsigned BLOCK_BYTES = BLOCK_W / BYTE_W;
  // Byte count must reach BLOCK_BYTES itself, hence one extra bit over the lane index.
  localparam int unsigned CNT_W       = $clog2(BLOCK_BYTES + 1);

  typedef enum logic [3:0] {
    StIdle    = 4'd0,
    StCollect = 4'd1,
    StFull    = 4'd2
  } sipo_state_e;

endpackage

// File: rtl/sipo_8to128_if.sv
// Byte-in / block-out bus of the deserializer.
//   in_valid, in : serial byte from the producer
//   clear        : consumer has taken the block
//   ready, valid : block accepting bytes / block complete
//   set_num      : bytes stored so far (0..16)
//   out          : assembled 128-bit block
//   overrun      : one-cycle pulse, byte dropped while full
// master = producer/consumer side, slave = deserializer.
interface sipo_8to128_if
  import sipo_8to128_pkg::*;
  ();

  logic               in_valid;
  logic [BYTE_W-1:0]  in;
  logic               clear;
  logic               ready;
  logic               valid;
  logic [CNT_W-1:0]   set_num;
  logic [BLOCK_W-1:0] out;
  logic               overrun;

  modport master (
    output in_valid, in, clear,
    input  ready, valid, set_num, out, overrun
  );

  modport slave (
    input  in_valid, in, clear,
    output ready, valid, set_num, out, overrun
  );

endinterface

// File: rtl/sipo_8to128.sv
// Byte-serial to 128-bit parallel deserializer (receive side of the AES data path).
// Byte k of a block lands in out[8k+7:8k]; the finished block is held with valid
// high until clear.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : sipo_8to128_if.slave (in_valid/in/clear in; ready/valid/set_num/out/overrun out)
// IN_N/OUT_N/SET_N must agree with the interface widths taken from the package.
module sipo_8to128
  import sipo_8to128_pkg::*;
#(
  parameter int unsigned IN_N  = BYTE_W,
  parameter int unsigned OUT_N = BLOCK_W,
  parameter int unsigned SET_N = BLOCK_BYTES
) (
  input  logic           clk,
  input  logic           reset,
  sipo_8to128_if.slave   bus
);

  localparam int unsigned CntW  = $clog2(SET_N + 1);
  localparam int unsigned LaneW = $clog2(SET_N);

  sipo_state_e      state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [OUT_N-1:0] out_q, out_d;
  logic             overrun_q, overrun_d;
  logic [SET_N-1:0] lane_we;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    out_d     = out_q;
    overrun_d = 1'b0;
    lane_we   = '0;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (bus.in_valid) begin
          lane_we[0] = 1'b1;
          cnt_d      = CntW'(1);
          state_d    = StCollect;
        end
      end
      StCollect: begin
        if (bus.in_valid) begin
          lane_we = {{(SET_N-1){1'b0}}, 1'b1} << cnt_q[LaneW-1:0];
          cnt_d   = cnt_q + CntW'(1);
          if (cnt_q == CntW'(SET_N - 1)) begin
            state_d = StFull;
          end
        end
      end
      StFull: begin
        // A byte arriving together with clear is dropped silently; the producer retries it.
        if (bus.clear) begin
          state_d = StIdle;
          cnt_d   = '0;
          out_d   = '0;
        end else if (bus.in_valid) begin
          overrun_d = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        out_d   = '0;
      end
    endcase

    for (int k = 0; k < SET_N; k++) begin
      if (lane_we[k]) begin
        out_d[k*IN_N +: IN_N] = bus.in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      out_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.ready   = (state_q != StFull);
  assign bus.valid   = (state_q == StFull);
  assign bus.set_num = cnt_q;
  assign bus.out     = out_q;
  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_sipo_8to128.sv
// Self-checking bench for sipo_8to128: a table of per-cycle vectors for the
// streaming/overrun/clear path, then hand-written multi-cycle sequences.
module tb_sipo_8to128;
  import sipo_8to128_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sipo_8to128_if bus ();

  sipo_8to128 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic         in_valid;
    logic [7:0]   data;
    logic         clear;
    logic         exp_valid;
    logic         exp_ready;
    logic [4:0]   exp_set;
    logic         exp_overrun;
    logic [127:0] exp_out;
  } vec_t;

  localparam int NumVec = 20;
  vec_t vecs[NumVec];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic c);
    bus.in_valid = v;
    bus.in       = d;
    bus.clear    = c;
  endtask

  task automatic check_state(input string name, input logic v, input logic [4:0] s,
                             input logic ov, input logic [127:0] o);
    check({name, ".valid"},   128'(bus.valid),   128'(v));
    check({name, ".ready"},   128'(bus.ready),   128'(!v));
    check({name, ".set_num"}, 128'(bus.set_num), 128'(s));
    check({name, ".overrun"}, 128'(bus.overrun), 128'(ov));
    check({name, ".out"},     bus.out,           o);
  endtask

  // Streams 16 bytes base..base+15 on consecutive cycles.
  task automatic send_block(input logic [7:0] base);
    for (int k = 0; k < 16; k++) begin
      drive(1'b1, base + 8'(k), 1'b0);
      tick();
    end
    drive(1'b0, 8'h00, 1'b0);
  endtask

  task automatic do_clear();
    drive(1'b0, 8'h00, 1'b1);
    tick();
    drive(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    logic [127:0] acc;
    logic [127:0] word;
    int           gaps;

    // Vector table: 16 back-to-back bytes, overrun in FULL, quiet cycle, clear, idle.
    acc = '0;
    for (int k = 0; k < 16; k++) begin
      acc[k*8 +: 8] = 8'(k);
      vecs[k] = '{1'b1, 8'(k), 1'b0, (k == 15), (k != 15), 5'(k + 1), 1'b0, acc};
    end
    vecs[16] = '{1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 5'd16, 1'b1,
                 128'h0F0E0D0C0B0A09080706050403020100};
    vecs[17] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd16, 1'b0,
                 128'h0F0E0D0C0B0A09080706050403020100};
    vecs[18] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 128'h0};
    vecs[19] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 128'h0};

    reset = 1'b1;
    drive(1'b0, 8'h00, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    check_state("reset", 1'b0, 5'd0, 1'b0, 128'h0);

    for (int i = 0; i < NumVec; i++) begin
      drive(vecs[i].in_valid, vecs[i].data, vecs[i].clear);
      tick();
      check({"vec", $sformatf("%0d", i), ".valid"}, 128'(bus.valid), 128'(vecs[i].exp_valid));
      check({"vec", $sformatf("%0d", i), ".ready"}, 128'(bus.ready), 128'(vecs[i].exp_ready));
      check({"vec", $sformatf("%0d", i), ".set_num"}, 128'(bus.set_num),
            128'(vecs[i].exp_set));
      check({"vec", $sformatf("%0d", i), ".overrun"}, 128'(bus.overrun),
            128'(vecs[i].exp_overrun));
      check({"vec", $sformatf("%0d", i), ".out"}, bus.out, vecs[i].exp_out);
    end
    drive(1'b0, 8'h00, 1'b0);

    // Gapped stream 0xA0..0xAF; clear pulsed during one gap must be ignored.
    for (int k = 0; k < 16; k++) begin
      drive(1'b1, 8'hA0 + 8'(k), 1'b0);
      tick();
      check("gap.set_num", 128'(bus.set_num), 128'(k + 1));
      check("gap.valid", 128'(bus.valid), 128'(k == 15));
      gaps = (k == 15) ? 0 : ((k == 3) ? 2 : int'($urandom_range(0, 5)));
      for (int g = 0; g < gaps; g++) begin
        drive(1'b0, 8'hEE, (k == 3 && g == 0));
        tick();
        check("gap.hold_set_num", 128'(bus.set_num), 128'(k + 1));
        check("gap.hold_valid", 128'(bus.valid), 128'(0));
      end
    end
    drive(1'b0, 8'h00, 1'b0);
    check("gap.out", bus.out, 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0);
    check("gap.ready", 128'(bus.ready), 128'(0));
    do_clear();
    check_state("gap.cleared", 1'b0, 5'd0, 1'b0, 128'h0);

    // clear and in_valid together in FULL: byte dropped, no overrun.
    send_block(8'h30);
    check("both.full_out", bus.out, 128'h3F3E3D3C3B3A39383736353433323130);
    drive(1'b1, 8'h77, 1'b1);
    tick();
    drive(1'b0, 8'h00, 1'b0);
    check_state("both.after", 1'b0, 5'd0, 1'b0, 128'h0);
    tick();
    check_state("both.settled", 1'b0, 5'd0, 1'b0, 128'h0);

    // Reset after 7 bytes discards them; next block assembles from lane 0.
    for (int k = 0; k < 7; k++) begin
      drive(1'b1, 8'hC0 + 8'(k), 1'b0);
      tick();
    end
    check("rst.partial_set", 128'(bus.set_num), 128'(7));
    check("rst.partial_out", bus.out, 128'h000000000000000000C6C5C4C3C2C1C0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    check_state("rst.after", 1'b0, 5'd0, 1'b0, 128'h0);
    send_block(8'h10);
    check_state("rst.fresh", 1'b1, 5'd16, 1'b0, 128'h1F1E1D1C1B1A19181716151413121110);
    do_clear();

    // Loopback: serializer behaviour emits lane 0 first during its TRANS phase.
    word = 128'h00112233445566778899AABBCCDDEEFF;
    for (int k = 0; k < 16; k++) begin
      drive(1'b1, word[k*8 +: 8], 1'b0);
      tick();
    end
    drive(1'b0, 8'h00, 1'b0);
    check_state("loop", 1'b1, 5'd16, 1'b0, 128'h00112233445566778899AABBCCDDEEFF);
    do_clear();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sipo_8to128.md
Name: sipo_8to128

Overview:
- Byte-serial to 128-bit parallel deserializer; the receive-side counterpart of the 128-to-8 serializer on the AES data path.
- Collects 16 bytes into one 128-bit block (plaintext, ciphertext or key) for the AES core.
- Holds the assembled block with `valid` asserted until the consumer issues `clear`.
- Byte lane ordering matches the serializer: byte k lands in bits [8k+7:8k], so a serializer-to-deserializer chain returns the original word.

Parameters:
- `IN_N`, 8, serial byte width.
- `OUT_N`, 128, parallel output width.
- `SET_N`, 16, bytes per block (`OUT_N` / `IN_N`).

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `in_valid`  input  1  `in` carries a byte this cycle.
- `in`  input  8  serial byte.
- `clear`  input  1  consumer has taken `out`; release the block and return to IDLE.
- `ready`  output  1  block can accept a byte this cycle.
- `valid`  output  1  `out` holds a complete 16-byte block.
- `set_num`  output  5  number of bytes stored so far, 0..16.
- `out`  output  128  assembled block (registered).
- `overrun`  output  1  one-cycle pulse: a byte arrived while FULL and was dropped.

Behaviour:
- Reset (synchronous, takes priority over everything):
  - state=IDLE, `cnt`=0, `out`=0, `overrun`=0.
  - Resulting outputs: `ready`=1, `valid`=0, `set_num`=0.
  - A reset mid-block discards all stored bytes at that edge.
- States: IDLE=0, COLLECT=1, FULL=2; other encodings go to IDLE.
- A byte is accepted when `in_valid` && `ready`.
- IDLE:
  - On `in_valid`: `in` is written to `out`[7:0], `cnt`←1, go to COLLECT.
  - Otherwise stay, `cnt`=0.
- COLLECT:
  - On `in_valid`: `in` is written to `out`[8·cnt+7 : 8·cnt], `cnt`←`cnt`+1.
  - If `cnt`==15 at acceptance, go to FULL with `cnt`←16.
  - When `in_valid`=0, hold state, `cnt` and `out`. Gaps of any length are legal.
- FULL:
  - `valid`=1, `ready`=0, `out` stable.
  - On `clear`: go to IDLE, `cnt`←0, `out`←0.
  - If `in_valid`=1 and `clear`=0: byte dropped, `overrun`=1 for that next cycle only.
  - If `in_valid`=1 and `clear`=1: byte dropped, no `overrun`; the producer must re-present it.
- `clear` in IDLE or COLLECT is ignored. No abort path exists; only `reset` abandons a partial block.
- Outputs:
  - `ready` = (state != FULL), combinational from state.
  - `valid` = (state == FULL), combinational from state.
  - `set_num` = `cnt` (5-bit, reaches 16).
- Latency: 16th byte accepted at edge N gives `valid`=1 and final `out` after edge N. Back-to-back streaming costs 16 cycles per block plus at least 1 cycle in FULL.
- Lane writes touch only the addressed byte; other lanes hold. Lane index uses `cnt`[3:0]. No writes occur when `cnt`=16.

Decomposition:
- Shared AES package holds:
  - state encodings IDLE/COLLECT/FULL (4-bit, aligned with the serializer's IDLE/TRANS/OVER numbering);
  - `BYTE_W`=8, `BLOCK_W`=128, `BLOCK_BYTES`=16.
- Single module. The byte-lane write-enable decode (4-to-16 one-hot from `cnt`[3:0] gated by accept) is small enough to stay inline; no sub-module.

Test Plan:
- Reset, then bytes 0x00..0x0F on 16 consecutive cycles → `valid`=1 one cycle after the 16th byte; `out`=128'h0F0E0D0C0B0A09080706050403020100; `set_num`=16; `ready`=0.
- Bytes 0xA0..0xAF with random `in_valid` gaps of 0-5 cycles → same lane mapping; `set_num` increments only on accepted bytes; `valid`=0 until the 16th byte.
- In FULL, `in_valid`=1 with 0x55 and `clear`=0 → `overrun` pulses exactly one cycle, `out` unchanged. Then `clear`=1 → next cycle `valid`=0, `set_num`=0, `out`=0.
- In FULL, `clear`=1 and `in_valid`=1 in the same cycle → IDLE next cycle, byte not stored, `overrun`=0, `set_num`=0.
- After 7 bytes, assert `reset` for one cycle → `set_num`=0, `out`=0. A fresh 16-byte block then assembles correctly.
- Loopback: serializer driving 128'h00112233445566778899AABBCCDDEEFF into this block (`in_valid` tied to the serializer's TRANS phase) → `out` equals the original word, `valid`=1.
